// File: rtl/input_vc_buffer_pkg.sv
// Shared NoC router types: flit formats, port routes, flit labels and
// flow-control / FIFO flavour selectors.
package noc_params;

  localparam int unsigned VC_NUM    = 2;
  localparam int unsigned VC_SIZE   = $clog2(VC_NUM);
  localparam int unsigned DATA_SIZE = 16;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic {ONOFF = 1'b0, CREDIT = 1'b1} flow_control_t;

  typedef enum logic [1:0] {ROUTER_FIFO, GENERIC_FIFO} fifo_type_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [VC_SIZE-1:0]   vc_id;
    logic [DATA_SIZE-1:0] data;
  } flit_t;

  typedef struct packed {
    flit_label_t          flit_label;
    logic [DATA_SIZE-1:0] data;
  } flit_novc_t;

  function automatic logic is_head(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_label_t l);
    return (l == TAIL) || (l == HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_buffer_fifo.sv
// First-word-fall-through flit FIFO; the head entry is always visible on rd_data_o.
module bram_fifo
  import noc_params::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = 8,
  parameter fifo_type_t  FIFO_TYPE = ROUTER_FIFO
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((FIFO_TYPE != ROUTER_FIFO) || (DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_cfg
    $error("bram_fifo: only power-of-two ROUTER_FIFO depths >= 4 are supported");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  always_comb begin
    push     = wr_en_i && (count_q != CW'(DEPTH));
    pop      = rd_en_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = mem_q[rd_ptr_q];
    count_o   = count_q;
    full_o    = (count_q == CW'(DEPTH));
    empty_o   = (count_q == '0);
  end

endmodule

// File: rtl/input_vc_buffer.sv
// Per-VC multi-packet input buffer: flit FIFO, per-packet route queue and
// IDLE/VA/SA read-side FSM with on/off or credit upstream flow control.
module input_vc_buffer
  import noc_params::*;
#(
  parameter int unsigned BUFFER_SIZE    = 8,
  parameter int unsigned MAX_PACKETS    = 2,
  parameter int unsigned FLOW_CONTROL   = 0,
  parameter int unsigned ON_OFF_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  flit_novc_t                    data_i,
  input  logic                          write_i,
  input  port_t                         out_port_i,
  input  logic                          read_i,
  input  logic                          vc_valid_i,
  input  logic [VC_SIZE-1:0]            vc_new_i,
  output flit_t                         data_o,
  output port_t                         out_port_o,
  output logic [VC_SIZE-1:0]            downstream_vc_o,
  output logic                          vc_request_o,
  output logic                          switch_request_o,
  output logic                          vc_allocatable_o,
  output logic                          credit_o,
  output logic                          on_off_o,
  output logic                          is_full_o,
  output logic                          is_empty_o,
  output logic [$clog2(BUFFER_SIZE):0]  count_o,
  output logic                          error_o
);

  localparam int unsigned CW    = $clog2(BUFFER_SIZE) + 1;
  localparam int unsigned OQ_AW = (MAX_PACKETS > 1) ? $clog2(MAX_PACKETS) : 1;
  localparam int unsigned OQ_CW = $clog2(MAX_PACKETS + 1);

  localparam flow_control_t FC_MODE     = (FLOW_CONTROL == 0) ? ONOFF : CREDIT;
  localparam logic          CREDIT_MODE = (FC_MODE == CREDIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] VA   = 2'd1;
  localparam logic [1:0] SA   = 2'd2;

  if ((MAX_PACKETS < 1) || (ON_OFF_LATENCY >= BUFFER_SIZE)) begin : g_bad_cfg
    $error("input_vc_buffer: unsupported MAX_PACKETS / ON_OFF_LATENCY");
  end

  function automatic logic [OQ_AW-1:0] oq_next(input logic [OQ_AW-1:0] p);
    return (p == OQ_AW'(MAX_PACKETS - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [1:0]           state_q, state_d;
  logic                 pkt_open_q, pkt_open_d;
  logic [VC_SIZE-1:0]   dvc_q, dvc_d;
  port_t                oq_q [MAX_PACKETS];
  logic [OQ_AW-1:0]     oq_wr_ptr_q, oq_wr_ptr_d;
  logic [OQ_AW-1:0]     oq_rd_ptr_q, oq_rd_ptr_d;
  logic [OQ_CW-1:0]     oq_cnt_q, oq_cnt_d;
  logic                 alloc_q, alloc_d;
  logic                 credit_q, credit_d;
  logic                 on_off_q, on_off_d;
  logic                 error_q, error_d;

  flit_novc_t           fifo_rd;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;

  logic                 head_w, head_ok, body_ok, push, pop, tail_pop, oq_full;
  logic [CW-1:0]        cnt_next;

  bram_fifo #(
    .DEPTH     (BUFFER_SIZE),
    .WIDTH     ($bits(flit_novc_t)),
    .FIFO_TYPE (ROUTER_FIFO)
  ) u_flit_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .wr_en_i   (push),
    .wr_data_i (data_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Acceptance is decided on pre-read occupancy, so a pop never frees room for a same-cycle write.
  always_comb begin
    oq_full  = (oq_cnt_q == OQ_CW'(MAX_PACKETS));
    head_w   = write_i && is_head(data_i.flit_label);
    head_ok  = head_w && !pkt_open_q && !fifo_full && !oq_full;
    body_ok  = write_i && !head_w && pkt_open_q && !fifo_full;
    push     = head_ok || body_ok;
    pop      = read_i && (state_q == SA) && !fifo_empty;
    tail_pop = pop && is_tail(fifo_rd.flit_label);
    cnt_next = fifo_count + CW'(push) - CW'(pop);
  end

  always_comb begin
    pkt_open_d = pkt_open_q;
    if (head_ok)                                    pkt_open_d = (data_i.flit_label == HEAD);
    else if (body_ok && data_i.flit_label == TAIL)  pkt_open_d = 1'b0;

    oq_wr_ptr_d = head_ok  ? oq_next(oq_wr_ptr_q) : oq_wr_ptr_q;
    oq_rd_ptr_d = tail_pop ? oq_next(oq_rd_ptr_q) : oq_rd_ptr_q;
    case ({head_ok, tail_pop})
      2'b10:   oq_cnt_d = oq_cnt_q + 1'b1;
      2'b01:   oq_cnt_d = oq_cnt_q - 1'b1;
      default: oq_cnt_d = oq_cnt_q;
    endcase
  end

  // oq_cnt_q still counts the packet in SA, so "another queued" means more than one.
  always_comb begin
    state_d = state_q;
    dvc_d   = dvc_q;
    case (state_q)
      IDLE: if ((oq_cnt_q != '0) || head_ok) state_d = VA;
      VA: begin
        if (vc_valid_i) begin
          dvc_d   = vc_new_i;
          state_d = SA;
        end
      end
      SA: begin
        if (tail_pop) state_d = ((oq_cnt_q > OQ_CW'(1)) || head_ok) ? VA : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alloc_d  = tail_pop;
    credit_d = CREDIT_MODE && pop;
    error_d  = (write_i && !push) || (read_i && !pop) || (vc_valid_i && (state_q != VA));
    on_off_d = on_off_q;
    if (pop && !push && (cnt_next <= CW'(ON_OFF_LATENCY)))
      on_off_d = 1'b1;
    else if (push && !pop && (cnt_next >= CW'(BUFFER_SIZE - ON_OFF_LATENCY)))
      on_off_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pkt_open_q  <= 1'b0;
      dvc_q       <= '0;
      oq_wr_ptr_q <= '0;
      oq_rd_ptr_q <= '0;
      oq_cnt_q    <= '0;
      alloc_q     <= 1'b0;
      credit_q    <= 1'b0;
      on_off_q    <= 1'b1;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pkt_open_q  <= pkt_open_d;
      dvc_q       <= dvc_d;
      oq_wr_ptr_q <= oq_wr_ptr_d;
      oq_rd_ptr_q <= oq_rd_ptr_d;
      oq_cnt_q    <= oq_cnt_d;
      alloc_q     <= alloc_d;
      credit_q    <= credit_d;
      on_off_q    <= on_off_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (head_ok) oq_q[oq_wr_ptr_q] <= out_port_i;
  end

  always_comb begin
    data_o.flit_label = fifo_rd.flit_label;
    data_o.vc_id      = dvc_q;
    data_o.data       = fifo_rd.data;
    out_port_o        = (oq_cnt_q == '0) ? LOCAL : oq_q[oq_rd_ptr_q];
    downstream_vc_o   = dvc_q;
    vc_request_o      = (state_q == VA);
    switch_request_o  = (state_q == SA) && !fifo_empty;
    vc_allocatable_o  = alloc_q;
    credit_o          = credit_q;
    on_off_o          = CREDIT_MODE ? 1'b1 : on_off_q;
    is_full_o         = fifo_full;
    is_empty_o        = fifo_empty;
    count_o           = fifo_count;
    error_o           = error_q;
  end

endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench: an on/off and a credit instance share stimulus; expected
// flits and routes are queued on accepted writes and compared on pops.
module tb_input_vc_buffer;
  import noc_params::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flit_novc_t         data_i;
  logic               write_i, read_i, vc_valid_i;
  port_t              out_port_i;
  logic [VC_SIZE-1:0] vc_new_i;

  flit_t              oo_data, cr_data;
  port_t              oo_port, cr_port;
  logic [VC_SIZE-1:0] oo_dvc, cr_dvc;
  logic               oo_vcreq, oo_swreq, oo_alloc, oo_credit, oo_onoff, oo_full, oo_empty, oo_err;
  logic               cr_vcreq, cr_swreq, cr_alloc, cr_credit, cr_onoff, cr_full, cr_empty, cr_err;
  logic [3:0]         oo_count, cr_count;

  input_vc_buffer #(.BUFFER_SIZE(8), .MAX_PACKETS(2), .FLOW_CONTROL(0), .ON_OFF_LATENCY(2)) dut_oo (
    .clk(clk), .resetn(rst_n), .data_i(data_i), .write_i(write_i), .out_port_i(out_port_i),
    .read_i(read_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i), .data_o(oo_data),
    .out_port_o(oo_port), .downstream_vc_o(oo_dvc), .vc_request_o(oo_vcreq),
    .switch_request_o(oo_swreq), .vc_allocatable_o(oo_alloc), .credit_o(oo_credit),
    .on_off_o(oo_onoff), .is_full_o(oo_full), .is_empty_o(oo_empty), .count_o(oo_count),
    .error_o(oo_err));

  input_vc_buffer #(.BUFFER_SIZE(8), .MAX_PACKETS(2), .FLOW_CONTROL(1), .ON_OFF_LATENCY(2)) dut_cr (
    .clk(clk), .resetn(rst_n), .data_i(data_i), .write_i(write_i), .out_port_i(out_port_i),
    .read_i(read_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i), .data_o(cr_data),
    .out_port_o(cr_port), .downstream_vc_o(cr_dvc), .vc_request_o(cr_vcreq),
    .switch_request_o(cr_swreq), .vc_allocatable_o(cr_alloc), .credit_o(cr_credit),
    .on_off_o(cr_onoff), .is_full_o(cr_full), .is_empty_o(cr_empty), .count_o(cr_count),
    .error_o(cr_err));

  int errors = 0;
  int checks = 0;

  flit_novc_t         exp_q[$];
  port_t              port_q[$];
  int                 cnt = 0;
  logic [VC_SIZE-1:0] exp_dvc = '0;
  logic [15:0]        dseq = 16'h0100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_common();
    port_t exp_port;
    exp_port = (port_q.size() == 0) ? LOCAL : port_q[0];
    check("count", 32'(oo_count), 32'(cnt));
    check("count_cr", 32'(cr_count), 32'(cnt));
    check("is_empty", 32'(oo_empty), 32'(cnt == 0));
    check("is_full", 32'(oo_full), 32'(cnt == 8));
    check("out_port", 32'(oo_port), 32'(exp_port));
    check("on_off_cr", 32'(cr_onoff), 32'd1);
  endtask

  task automatic check_reset();
    check("rst_count", 32'(oo_count), 32'd0);
    check("rst_empty", 32'(oo_empty), 32'd1);
    check("rst_full", 32'(oo_full), 32'd0);
    check("rst_port", 32'(oo_port), 32'(LOCAL));
    check("rst_dvc", 32'(oo_dvc), 32'd0);
    check("rst_onoff", 32'(oo_onoff), 32'd1);
    check("rst_onoff_cr", 32'(cr_onoff), 32'd1);
    check("rst_vcreq", 32'(oo_vcreq), 32'd0);
    check("rst_swreq", 32'(oo_swreq), 32'd0);
    check("rst_alloc", 32'(oo_alloc), 32'd0);
    check("rst_credit_cr", 32'(cr_credit), 32'd0);
    check("rst_err", 32'(oo_err), 32'd0);
  endtask

  // One cycle: optional write (acc = expected accepted) and optional valid pop.
  task automatic xfer(input logic w, input flit_label_t lb, input port_t p,
                      input logic acc, input logic r, input logic exp_err);
    flit_novc_t f, e;
    logic       tail_pop;
    f.flit_label = lb;
    f.data       = dseq;
    dseq         = dseq + 16'd1;
    write_i      = w;
    data_i       = f;
    out_port_i   = p;
    read_i       = r;
    tail_pop     = 1'b0;
    if (r) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_o", 32'(oo_data), 32'({e.flit_label, exp_dvc, e.data}));
        check("swreq", 32'(oo_swreq), 32'd1);
        tail_pop = is_tail(e.flit_label);
        cnt--;
      end
    end
    if (tail_pop) void'(port_q.pop_front());
    if (w && acc) begin
      exp_q.push_back(f);
      cnt++;
      if (is_head(lb)) port_q.push_back(p);
    end
    step();
    write_i = 1'b0;
    read_i  = 1'b0;
    check("error_o", 32'(oo_err), 32'(exp_err));
    check("alloc", 32'(oo_alloc), 32'(tail_pop));
    check("credit_cr", 32'(cr_credit), 32'(r));
    check("credit_oo", 32'(oo_credit), 32'd0);
    check_common();
  endtask

  task automatic vcg(input logic [VC_SIZE-1:0] vc, input logic exp_err);
    vc_valid_i = 1'b1;
    vc_new_i   = vc;
    step();
    vc_valid_i = 1'b0;
    if (!exp_err) exp_dvc = vc;
    check("vc_err", 32'(oo_err), 32'(exp_err));
    check("dvc", 32'(oo_dvc), 32'(exp_dvc));
    check("dvc_cr", 32'(cr_dvc), 32'(exp_dvc));
    check_common();
  endtask

  task automatic bad_read();
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    check("rd_err", 32'(oo_err), 32'd1);
    check("rd_err_credit", 32'(cr_credit), 32'd0);
    check_common();
  endtask

  initial begin
    rst_n = 1'b0; write_i = 1'b0; read_i = 1'b0; vc_valid_i = 1'b0;
    vc_new_i = '0; out_port_i = LOCAL; data_i = '0;
    repeat (2) step();
    check_reset();
    rst_n = 1'b1;
    step();

    // single HEADTAIL packet
    xfer(1, HEADTAIL, EAST, 1, 0, 0);
    check("t1_vcreq", 32'(oo_vcreq), 32'd1);
    vcg(1, 0);
    check("t1_swreq", 32'(oo_swreq), 32'd1);
    check("t1_vcreq_sa", 32'(oo_vcreq), 32'd0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t1_idle_vcreq", 32'(oo_vcreq), 32'd0);
    check("t1_idle_swreq", 32'(oo_swreq), 32'd0);
    xfer(0, BODY, LOCAL, 0, 0, 0);

    // back-to-back packets, no IDLE bubble
    xfer(1, HEAD, NORTH, 1, 0, 0);
    check("t2_vcreq", 32'(oo_vcreq), 32'd1);
    vcg(0, 0);
    xfer(1, BODY, LOCAL, 1, 0, 0);
    xfer(1, TAIL, LOCAL, 1, 0, 0);
    xfer(1, HEAD, SOUTH, 1, 0, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t2_still_sa", 32'(oo_vcreq), 32'd0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t2_va_after_tail", 32'(oo_vcreq), 32'd1);
    xfer(1, TAIL, LOCAL, 1, 0, 0);
    vcg(1, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    xfer(1, HEADTAIL, WEST, 1, 1, 0);
    check("t2_va_same_cycle_head", 32'(oo_vcreq), 32'd1);
    vcg(0, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t2_idle", 32'(oo_vcreq), 32'd0);

    // on/off hysteresis, full rejection, credit pulses
    xfer(1, HEAD, WEST, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      xfer(1, BODY, LOCAL, 1, 0, 0);
      check("t3_onoff_fill", 32'(oo_onoff), 32'(cnt < 6));
    end
    xfer(1, BODY, LOCAL, 0, 0, 1);
    check("t3_onoff_full", 32'(oo_onoff), 32'd0);
    vcg(0, 0);
    xfer(1, BODY, LOCAL, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      xfer(0, BODY, LOCAL, 0, 1, 0);
      check("t3_onoff_drain", 32'(oo_onoff), 32'd0);
    end
    xfer(1, TAIL, LOCAL, 1, 1, 0);
    check("t3_onoff_pushpop", 32'(oo_onoff), 32'd0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t3_onoff_at2", 32'(oo_onoff), 32'd1);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    xfer(0, BODY, LOCAL, 0, 0, 0);

    // protocol errors
    xfer(1, BODY, LOCAL, 0, 0, 1);
    check("t5_body_idle", 32'(oo_vcreq), 32'd0);
    xfer(0, BODY, LOCAL, 0, 0, 0);
    xfer(1, HEAD, NORTH, 1, 0, 0);
    xfer(1, HEAD, EAST, 0, 0, 1);
    xfer(1, TAIL, LOCAL, 1, 0, 0);
    xfer(1, HEADTAIL, SOUTH, 1, 0, 0);
    xfer(1, HEAD, EAST, 0, 0, 1);
    bad_read();
    check("t5_va_kept", 32'(oo_vcreq), 32'd1);
    vcg(1, 0);
    vcg(0, 1);
    check("t5_sa_kept", 32'(oo_swreq), 32'd1);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);
    check("t5_next_va", 32'(oo_vcreq), 32'd1);
    vcg(0, 0);
    xfer(0, BODY, LOCAL, 0, 1, 0);

    // asynchronous reset mid-packet
    xfer(1, HEAD, EAST, 1, 0, 0);
    xfer(1, BODY, LOCAL, 1, 0, 0);
    xfer(1, BODY, LOCAL, 1, 0, 0);
    vcg(1, 0);
    check("t6_sa", 32'(oo_swreq), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    port_q.delete();
    cnt = 0;
    exp_dvc = '0;
    check_reset();
    step();
    check_reset();
    rst_n = 1'b1;
    step();
    xfer(1, HEAD, NORTH, 1, 0, 0);
    check("t6_head_after_rst", 32'(oo_vcreq), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
# input_vc_buffer

Per-VC input buffer for the router input port that holds several packets at once. It is the multi-packet, mode-selectable successor of the single-packet input buffer. It accepts the head of packet N+1 while packet N is still draining through switch allocation, and it queues each packet's routed output port. It supports either on/off or credit-based upstream flow control. One instance sits per virtual channel inside the input port, between the link receiver and the VC/switch allocators.

## Interface
Parameters:
- BUFFER_SIZE, 8, flit storage depth (power of two, ≥4)
- MAX_PACKETS, 2, depth of the per-packet out-port queue (≥1)
- FLOW_CONTROL, 0, 0 = on/off, 1 = credit
- ON_OFF_LATENCY, 2, on/off hysteresis margin in flits

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- data_i  in  flit_novc_t  incoming flit
- write_i  in  1  flit valid on data_i
- out_port_i  in  port_t  route computed for the flit on data_i (sampled on head writes only)
- read_i  in  1  crossbar grant; pops one flit
- vc_valid_i  in  1  VC allocator grant
- vc_new_i  in  VC_SIZE  granted downstream VC
- data_o  out  flit_t  head flit, with vc_id = downstream_vc_o
- out_port_o  out  port_t  out-port queue head; LOCAL when the queue is empty
- downstream_vc_o  out  VC_SIZE  latched downstream VC
- vc_request_o  out  1  high in VA
- switch_request_o  out  1  high in SA when the flit FIFO is non-empty
- vc_allocatable_o  out  1  one-cycle pulse after a packet's tail leaves
- credit_o  out  1  one-cycle pulse per popped flit (credit mode; 0 otherwise)
- on_off_o  out  1  upstream may send (on/off mode; constant 1 in credit mode)
- is_full_o / is_empty_o  out  1  flit FIFO status
- count_o  out  $clog2(BUFFER_SIZE)+1  flit occupancy
- error_o  out  1  registered one-cycle protocol-error pulse

## Operation
- **Write side** tracks `pkt_open`.
  - HEAD is accepted when `pkt_open` = 0, the flit FIFO is not full, and the out-port queue is not full. On accept, out_port_i is pushed to the out-port queue. HEAD sets `pkt_open`; HEADTAIL leaves it clear.
  - BODY/TAIL is accepted when `pkt_open` = 1 and the flit FIFO is not full. TAIL clears `pkt_open`.
  - Any other write is dropped and raises error_o.
- **Full check** uses pre-read state: a write while full is rejected even if read_i is high in the same cycle.
- **Read-side FSM**:
  - **IDLE**: goes to VA next cycle if the out-port queue is non-empty or a head write is accepted this cycle.
  - **VA**: vc_request_o = 1. On vc_valid_i, latch vc_new_i into downstream_vc_o and go to SA.
  - **SA**: read_i pops the flit FIFO. If the popped flit is TAIL/HEADTAIL, pop the out-port queue, pulse vc_allocatable_o next cycle, then:
    - go to VA if another packet is queued (including a head written this cycle);
    - otherwise go to IDLE.
- **error_o** is set, next cycle, by any of:
  - a dropped write;
  - read_i outside SA or with the FIFO empty (read ignored);
  - vc_valid_i outside VA (ignored).
- **on_off_o** is registered:
  - set when a pop-only cycle leaves count ≤ ON_OFF_LATENCY;
  - cleared when a push-only cycle leaves count ≥ BUFFER_SIZE − ON_OFF_LATENCY;
  - otherwise held.
- **credit_o** is registered from the pop.
- **Reset values**:
  - FSM IDLE, FIFO and queue empty, `pkt_open` = 0;
  - out_port_o = LOCAL, downstream_vc_o = 0, count_o = 0, is_empty_o = 1, is_full_o = 0;
  - on_off_o = 1;
  - all request, pulse and error outputs 0.
- **Mid-packet reset**: resetn low discards all contents immediately; no credits are returned for discarded flits.

## Timing
- data_o is first-word-fall-through: a flit written into an empty FIFO at edge t is visible on data_o after t.
- Head written in cycle 0 into an idle buffer → vc_request_o in cycle 1.
- vc_valid_i in cycle k → switch_request_o in cycle k+1 (if non-empty).
- Pop at edge t → credit_o high during cycle t+1, count_o updated after t.
- A tail pop with a queued packet gives VA the next cycle, so there is no IDLE bubble. out_port_o shows the next route in that same cycle.
- Simultaneous push and pop leaves count, on_off_o and is_full_o unchanged.

## Structure
- noc_params gains a flow-control mode enum (ONOFF, CREDIT). flit_t, flit_novc_t, port_t, VC_SIZE and the flit labels are already there.
- Flit storage is a bram_fifo instance (ROUTER_FIFO type, FWFT).
- The out-port queue is a small inline register FIFO of MAX_PACKETS entries; no further sub-module.

## Test plan
1. Reset, then HEADTAIL write with out_port_i = EAST → cycle 1 vc_request_o = 1, out_port_o = EAST. Then vc_valid_i with vc_new_i = 1 → SA, data_o.vc_id = 1. Then read → vc_allocatable_o pulse, FSM back to IDLE.
2. Packet A (HEAD, BODY, TAIL to NORTH) followed by packet B (HEAD to SOUTH) while A is in SA. A's tail pop → VA next cycle with out_port_o = SOUTH, with no IDLE cycle between them.
3. BUFFER_SIZE = 8, on/off mode: 6 writes → on_off_o = 0 after the 6th. Drain to 2 → on_off_o = 1. A 9th write while full → dropped, error_o pulse, count stays 8.
4. Credit mode: 4 pops on consecutive cycles → 4 consecutive credit_o pulses, each one cycle after its pop. on_off_o stays 1 throughout.
5. Protocol errors produce one error_o pulse each, with state unchanged:
   - BODY with no open packet;
   - HEAD while a packet is open;
   - HEAD with the out-port queue full (MAX_PACKETS = 2);
   - read_i in VA;
   - vc_valid_i in SA.
6. resetn asserted mid-packet in SA with count = 3 → all outputs return to their reset values immediately. A HEAD after release is accepted normally.
